float_max_reduce: RTL and testbench
===================================

Name: float_max_reduce

Overview:
- Streaming arg-max reduction over packets of custom-format floats: {exc[1:0], sign, exponent, mantissa}, with exc 00=zero, 01=normal, 10=inf, 11=NaN.
- Sits directly downstream of the float comparator. It instantiates compare_float to test each incoming element against the registered running best.
- Emits the packet maximum, its index and the packet length once per packet. Used by the rasteriser/shader for bounding and max-Z reductions.

Parameters:
- EXPONENT, 7, exponent field width.
- MANTISSA, 17, mantissa field width.
- IDX_W, 16, width of index and count outputs.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  EXPONENT+MANTISSA+3  float element.
- in_last  in  1  final element of packet; qualified by in_valid.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_max  out  EXPONENT+MANTISSA+3  packet maximum.
- out_index  out  IDX_W  zero-based position of out_max within the packet.
- out_count  out  IDX_W  number of elements in the packet.

Behaviour:
- Interface is decided as: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: in_ready=1, out_valid=0, out_max=0, out_index=0, out_count=0. State=ACCUM, first flag=1.
- A beat is accepted when in_valid && in_ready. A result is taken when out_valid && out_ready.
- State ACCUM:
  - in_ready=1.
  - An accepted beat with first=1 loads best<=in_data, best_idx<=0, cnt<=1, first<=0. No compare is used.
  - An accepted beat with first=0 replaces best/best_idx(<=cnt) only if compare_float(X=in_data, Y=best) is 1. cnt increments.
  - Comparison is strict, so ties keep the earliest element. +0 vs -0 is a tie.
  - Accepted beat with in_last=1:
    - The final decision, including that beat, is written to out_max/out_index/out_count.
    - out_count is the updated cnt.
    - Next state is HOLD, and first<=1.
  - A single-element packet (first=1 and in_last=1) gives out_index=0, out_count=1.
- State HOLD:
  - in_ready=0 and out_valid=1.
  - Outputs are stable until taken.
  - When taken, the block returns to ACCUM and out_valid drops. Outputs keep their last values.
  - No beat is accepted in the same cycle; the first new beat is accepted one cycle after the take.
- Latency: out_valid asserts the cycle after the last beat. Throughput is 1 element/cycle within a packet, plus 1 bubble cycle per packet.
- The compare path is combinational: in_data against registered best, feeding the best register.
- cnt saturates at 2^IDX_W-1. Elements beyond that still compete for max, but their reported index saturates at the same value.
- Default NaN handling follows compare_float encoding: NaN (exc 11) outranks inf and normals. Among NaNs, the raw-bit compare decides.
- Reset mid-packet or in HOLD discards all state and returns to reset values. A pending result is lost.
- in_last without in_valid is ignored.

Optional Feature:
- Macro: FLOAT_MAX_NAN_SKIP_EN.
- Defined:
  - A NaN element never replaces a non-NaN best.
  - A non-NaN element always replaces a NaN best.
  - The first element still loads unconditionally.
  - Result: out_max is NaN only if every element is NaN, in which case it is the first one.
  - cnt still counts NaN elements.
- Undefined: NaN ordering follows compare_float as above.

Decomposition:
- Shared package float_pkg holds:
  - exception-code localparams EXC_ZERO=2'b00, EXC_NORM=2'b01, EXC_INF=2'b10, EXC_NAN=2'b11;
  - a width function fp_width(EXPONENT,MANTISSA)=EXPONENT+MANTISSA+3;
  - the state typedef enum {ACCUM, HOLD}.
- Sub-module: one instance of the existing compare_float. No new sub-module is needed.

Test Plan:
- Packet +1.0, -3.0, +2.0, +2.0(last) with out_ready=1 -> out_max=+2.0, out_index=2, out_count=4. out_valid asserts exactly 1 cycle after the last beat.
- Single beat -5.0 with in_last=1 -> out_max=-5.0, out_index=0, out_count=1.
- Packet -0.0, +0.0(last) -> out_max=-0.0 (tie keeps first), out_index=0.
- Packet +1.0, NaN, +inf(last):
  - macro off -> out_max=NaN, index 1;
  - macro on -> out_max=+inf, index 2, count 3.
- Backpressure: hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout. On take, in_ready=1 the next cycle and the next packet is reduced independently.
- Assert reset after 2 beats of a packet, then send 7.0(last) -> out_max=7.0, out_index=0, out_count=1. No stale result is emitted.

Source files
------------

// File: rtl/float_pkg.sv
// Shared definitions for the custom float format {exc[1:0], sign, exponent, mantissa}.
package float_pkg;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  function automatic int fp_width(input int exponent, input int mantissa);
    return exponent + mantissa + 3;
  endfunction

  typedef enum logic {ACCUM, HOLD} state_t;

endpackage

// File: rtl/compare_float.sv
// Strict greater-than for custom floats: out = (X > Y). NaN outranks everything,
// NaN vs NaN falls back to raw bits, +0 and -0 compare equal.
module compare_float import float_pkg::*; #(
  parameter int EXPONENT = 7,
  parameter int MANTISSA = 17
) (
  input  logic [fp_width(EXPONENT, MANTISSA)-1:0] X,
  input  logic [fp_width(EXPONENT, MANTISSA)-1:0] Y,
  output logic                                    out
);
  localparam int W  = fp_width(EXPONENT, MANTISSA);
  localparam int MW = EXPONENT + MANTISSA + 2;

  logic [1:0]    xe, ye;
  logic [MW-1:0] xm, ym;
  logic          xneg, yneg;

  // Magnitude key {exc, exp, mant} is monotonic once zero/inf payloads are cleared.
  always_comb begin
    xe   = X[W-1 -: 2];
    ye   = Y[W-1 -: 2];
    xm   = {xe, X[W-4:0]};
    ym   = {ye, Y[W-4:0]};
    if (xe == EXC_ZERO || xe == EXC_INF) xm = {xe, {(MW-2){1'b0}}};
    if (ye == EXC_ZERO || ye == EXC_INF) ym = {ye, {(MW-2){1'b0}}};
    xneg = X[W-3] && (xe != EXC_ZERO);
    yneg = Y[W-3] && (ye != EXC_ZERO);
    out  = 1'b0;
    if (xe == EXC_NAN && ye == EXC_NAN) out = X > Y;
    else if (xe == EXC_NAN)             out = 1'b1;
    else if (ye == EXC_NAN)             out = 1'b0;
    else if (!xneg && !yneg)            out = xm > ym;
    else if (!xneg && yneg)             out = 1'b1;
    else if (xneg && !yneg)             out = 1'b0;
    else                                out = xm < ym;
  end

endmodule

// File: rtl/float_max_reduce.sv
// Streaming per-packet arg-max over custom floats; one result per packet.
// Optional macro FLOAT_MAX_NAN_SKIP_EN: NaNs lose to any non-NaN element.
module float_max_reduce import float_pkg::*; #(
  parameter int EXPONENT = 7,
  parameter int MANTISSA = 17,
  parameter int IDX_W    = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [fp_width(EXPONENT, MANTISSA)-1:0] in_data,
  input  logic                                    in_last,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [fp_width(EXPONENT, MANTISSA)-1:0] out_max,
  output logic [IDX_W-1:0]                        out_index,
  output logic [IDX_W-1:0]                        out_count
);
  localparam int W = fp_width(EXPONENT, MANTISSA);
  localparam logic [IDX_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic             first;
  logic [W-1:0]     best, best_nxt;
  logic [IDX_W-1:0] best_idx, idx_nxt, cnt, cnt_nxt;
  logic             accept, gt, replace;

  compare_float #(.EXPONENT(EXPONENT), .MANTISSA(MANTISSA)) u_cmp (
    .X   (in_data),
    .Y   (best),
    .out (gt)
  );

`ifdef FLOAT_MAX_NAN_SKIP_EN
  logic in_nan, best_nan;
  assign in_nan   = in_data[W-1 -: 2] == EXC_NAN;
  assign best_nan = best[W-1 -: 2] == EXC_NAN;
  assign replace  = best_nan ? !in_nan : (!in_nan && gt);
`else
  assign replace  = gt;
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Candidate best after the current beat; also the packet result on in_last.
  always_comb begin
    best_nxt = best;
    idx_nxt  = best_idx;
    cnt_nxt  = (cnt == CNT_MAX) ? cnt : cnt + IDX_W'(1);
    if (first) begin
      best_nxt = in_data;
      idx_nxt  = '0;
      cnt_nxt  = IDX_W'(1);
    end else if (replace) begin
      best_nxt = in_data;
      idx_nxt  = cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first     <= 1'b1;
      best      <= '0;
      best_idx  <= '0;
      cnt       <= '0;
      out_max   <= '0;
      out_index <= '0;
      out_count <= '0;
    end else if (accept) begin
      best     <= best_nxt;
      best_idx <= idx_nxt;
      cnt      <= cnt_nxt;
      first    <= in_last;
      if (in_last) begin
        out_max   <= best_nxt;
        out_index <= idx_nxt;
        out_count <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_float_max_reduce.sv
// Directed and randomized packets checked against a real-valued arg-max model.
module tb_float_max_reduce;
  localparam int E = 7;
  localparam int M = 17;
  localparam int IW = 4;
  localparam int W = E + M + 3;
  localparam int SAT = (1 << IW) - 1;

  logic          clk = 0;
  logic          reset = 1;
  logic          in_valid = 0, in_last = 0, out_ready = 0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_max;
  logic [IW-1:0] out_index, out_count;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] pkt[$];

  float_max_reduce #(.EXPONENT(E), .MANTISSA(M), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_max(out_max), .out_index(out_index),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [1:0] exc, input logic s,
                                      input int e, input int m);
    logic [W-1:0] r;
    r = {exc, s, E'(e), M'(m)};
    return r;
  endfunction

  function automatic bit is_nan(input logic [W-1:0] x);
    return x[W-1 -: 2] == 2'b11;
  endfunction

  // Numeric value with bias 63 and implicit leading one; inf as a huge finite.
  function automatic real fval(input logic [W-1:0] x);
    real v;
    case (x[W-1 -: 2])
      2'b00:   v = 0.0;
      2'b10:   v = 1.0e300;
      default: v = (1.0 + real'(x[M-1:0]) / 131072.0) * (2.0 ** (real'(x[M+E-1:M]) - 63.0));
    endcase
    return x[W-3] ? -v : v;
  endfunction

  function automatic void model(output logic [W-1:0] emax, output int eidx, output int ecnt);
    int bi = 0;
    bit found = 0;
`ifdef FLOAT_MAX_NAN_SKIP_EN
    foreach (pkt[i])
      if (!is_nan(pkt[i]) && (!found || fval(pkt[i]) > fval(pkt[bi]))) begin
        found = 1; bi = i;
      end
    if (!found) bi = 0;
`else
    foreach (pkt[i])
      if (is_nan(pkt[i]) && (!found || pkt[i] > pkt[bi])) begin
        found = 1; bi = i;
      end
    if (!found) begin
      bi = 0;
      foreach (pkt[i]) if (fval(pkt[i]) > fval(pkt[bi])) bi = i;
    end
`endif
    emax = pkt[bi];
    eidx = (bi > SAT) ? SAT : bi;
    ecnt = (pkt.size() > SAT) ? SAT : pkt.size();
  endfunction

  function automatic logic [W-1:0] rand_elem(input logic [W-1:0] prev);
    int r = $urandom_range(0, 99);
    logic [W-1:0] x;
    if (r < 10)      x = prev;
    else if (r < 20) x = mk(2'b00, 1'($urandom), 0, 0);
    else if (r < 28) x = mk(2'b10, 1'($urandom), 0, 0);
    else if (r < 38) x = mk(2'b11, 1'($urandom), $urandom_range(0, 127), $urandom);
    else             x = mk(2'b01, 1'($urandom), $urandom_range(55, 72), $urandom);
    return x;
  endfunction

  task automatic send_pkt(input int hold, input logic [W-1:0] emax, input int eidx, input int ecnt);
    for (int i = 0; i < pkt.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 0; in_last = 1; in_data = W'($urandom);
      end
      @(negedge clk);
      chk("in_ready_accum", in_ready, 1);
      chk("out_valid_accum", out_valid, 0);
      in_valid = 1; in_data = pkt[i]; in_last = (i == pkt.size() - 1);
    end
    @(negedge clk);
    in_valid = 1; in_last = 1; in_data = W'($urandom);
    out_ready = (hold == 0);
    chk("out_valid_latency", out_valid, 1);
    chk("out_max", out_max, emax);
    chk("out_index", out_index, eidx);
    chk("out_count", out_count, ecnt);
    chk("in_ready_hold", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_max", out_max, emax);
      chk("hold_index", out_index, eidx);
      chk("hold_count", out_count, ecnt);
      if (h == hold - 1) out_ready = 1;
    end
    @(negedge clk);
    in_valid = 0; in_last = 0; out_ready = 0;
    chk("taken_valid", out_valid, 0);
    chk("taken_in_ready", in_ready, 1);
    chk("taken_keep_max", out_max, emax);
  endtask

  initial begin
    logic [W-1:0] p1, m3, p2, m5, p7, nan, pinf, pz, nz, emax, prev;
    int eidx, ecnt, n;
    p1   = mk(2'b01, 0, 63, 0);
    m3   = mk(2'b01, 1, 64, 65536);
    p2   = mk(2'b01, 0, 64, 0);
    m5   = mk(2'b01, 1, 65, 32768);
    p7   = mk(2'b01, 0, 65, 98304);
    nan  = mk(2'b11, 0, 0, 0);
    pinf = mk(2'b10, 0, 0, 0);
    pz   = mk(2'b00, 0, 0, 0);
    nz   = mk(2'b00, 1, 0, 0);

    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_max", out_max, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_count", out_count, 0);

    pkt = '{p1, m3, p2, p2};
    send_pkt(0, p2, 2, 4);
    pkt = '{m5};
    send_pkt(0, m5, 0, 1);
    pkt = '{nz, pz};
    send_pkt(0, nz, 0, 2);
    pkt = '{p1, nan, pinf};
`ifdef FLOAT_MAX_NAN_SKIP_EN
    send_pkt(0, pinf, 2, 3);
`else
    send_pkt(0, nan, 1, 3);
`endif
    pkt = '{m3, p7, m5};
    send_pkt(5, p7, 1, 3);
    pkt = '{p2, p1};
    send_pkt(0, p2, 0, 2);

    // reset in the middle of a packet
    @(negedge clk); in_valid = 1; in_data = p7; in_last = 0;
    @(negedge clk); in_data = pinf;
    @(negedge clk); in_valid = 0; reset = 1;
    @(negedge clk); reset = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_max", out_max, 0);
    chk("midrst_out_count", out_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    pkt = '{p7};
    send_pkt(0, p7, 0, 1);

    // count/index saturation
    pkt = {};
    for (int i = 0; i < 20; i++) pkt.push_back(mk(2'b01, 0, 60, i));
    send_pkt(0, pkt[19], SAT, SAT);

    for (int k = 0; k < 30; k++) begin
      pkt = {};
      n = $urandom_range(1, 9);
      prev = p1;
      for (int i = 0; i < n; i++) begin
        prev = rand_elem(prev);
        pkt.push_back(prev);
      end
      model(emax, eidx, ecnt);
      send_pkt($urandom_range(0, 2), emax, eidx, ecnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
